// File: rtl/mul_disp_pkg.sv
// Shared defaults and helpers for the multiplier result display path.
// Helpers are sized for the largest supported word; callers truncate to their own width.
package mul_disp_pkg;

  localparam int DIGIT_W_DEF    = 4;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int SCAN_DIV_DEF   = 1000;
  localparam int MAX_DIGITS     = 32;
  localparam int MAX_WORD       = 256;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    logic [MAX_DIGITS-1:0] v;
    for (int k = 0; k < MAX_DIGITS; k++) v[k] = (idx == unsigned'(k));
    return v;
  endfunction

  // Bit d is set when digits d..num_digits-1 are all zero.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [MAX_WORD-1:0] word,
                                                    input int digit_w,
                                                    input int num_digits);
    logic [MAX_WORD-1:0]   dmask;
    logic [MAX_WORD-1:0]   shifted;
    logic [MAX_DIGITS-1:0] m;
    logic                  still_zero;
    dmask      = ~({MAX_WORD{1'b1}} << digit_w);
    m          = '0;
    still_zero = 1'b1;
    for (int d = MAX_DIGITS - 1; d >= 0; d--) begin
      if (d < num_digits) begin
        shifted    = word >> (d * digit_w);
        still_zero = still_zero & ~(|(shifted & dmask));
        m[d]       = still_zero;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divides the enabled clock into one scan tick every SCAN_DIV cycles.
// The count freezes while en is low so a paused digit resumes where it stopped.
module scan_prescaler
  import mul_disp_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             at_last;

  always_comb begin
    at_last   = (div_cnt_q == LAST_CNT);
    tick      = en && at_last;
    div_cnt_d = div_cnt_q;
    if (en) div_cnt_d = at_last ? '0 : div_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner with double-buffered word load, leading-zero
// blanking and a frame-done pulse; outputs are registered from pre-update state.
module digit_scan_mux
  import mul_disp_pkg::*;
#(
  parameter int DIGIT_W    = DIGIT_W_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int SCAN_DIV   = SCAN_DIV_DEF,
  parameter int LZ_BLANK   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] in,
  input  logic                          load,
  input  logic                          en,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          blank,
  output logic                          frame_done
);

  localparam int WORD_W = DIGIT_W * NUM_DIGITS;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                  tick, wrap;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     disp_word_q, disp_word_d;
  logic [WORD_W-1:0]     pend_word_q, pend_word_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DIGIT_W-1:0]    digit_out_q, digit_out_d, cur_digit;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic                  blank_q, blank_d;
  logic                  frame_done_q, frame_done_d;
  logic                  cur_lz;
  logic [MAX_WORD-1:0]   disp_ext;
  logic [NUM_DIGITS-1:0] lz_vec, sel_vec;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign wrap = tick && (idx_q == LAST_IDX);

  // A load in the commit cycle lands in the pending buffer after the old value moves out.
  always_comb begin
    idx_d        = idx_q;
    disp_word_d  = disp_word_q;
    pend_word_d  = pend_word_q;
    pend_valid_d = pend_valid_q;
    if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    if (wrap && pend_valid_q) begin
      disp_word_d  = pend_word_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_word_d  = in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    disp_ext                = '0;
    disp_ext[WORD_W-1:0]    = disp_word_q;
    lz_vec                  = NUM_DIGITS'(lz_mask(disp_ext, DIGIT_W, NUM_DIGITS));
    sel_vec                 = NUM_DIGITS'(onehot(32'(idx_q)));
    cur_digit               = '0;
    cur_lz                  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit = disp_word_q[k*DIGIT_W +: DIGIT_W];
        cur_lz    = lz_vec[k];
      end
    end
    digit_out_d  = digit_out_q;
    digit_sel_d  = '0;
    blank_d      = 1'b1;
    frame_done_d = 1'b0;
    if (en) begin
      digit_out_d  = cur_digit;
      digit_sel_d  = sel_vec;
      blank_d      = (LZ_BLANK != 0) && (idx_q != '0) && cur_lz;
      frame_done_d = wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      disp_word_q  <= '0;
      pend_word_q  <= '0;
      pend_valid_q <= 1'b0;
      digit_out_q  <= '0;
      digit_sel_q  <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      disp_word_q  <= disp_word_d;
      pend_word_q  <= pend_word_d;
      pend_valid_q <= pend_valid_d;
      digit_out_q  <= digit_out_d;
      digit_sel_q  <= digit_sel_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_out  = digit_out_q;
  assign digit_sel  = digit_sel_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench: three scanner builds (SCAN_DIV=3 with and without blanking,
// SCAN_DIV=1) share one stimulus stream and are compared against a behavioural model.
module tb_digit_scan_mux;

  localparam int NI = 3;

  typedef struct packed {
    logic [3:0] dout;
    logic [3:0] sel;
    logic       blank;
    logic       fd;
  } exp_t;
  typedef exp_t [NI-1:0] row_t;

  logic        clk = 1'b0;
  logic        rst, load, en;
  logic [15:0] in_w;
  logic [3:0]  dout_w  [NI];
  logic [3:0]  sel_w   [NI];
  logic        blank_w [NI];
  logic        fd_w    [NI];

  int checks = 0;
  int passes = 0;
  row_t sb_q [$];

  logic [15:0] m_disp [NI];
  logic [15:0] m_pend [NI];
  logic        m_pv   [NI];
  int          m_div  [NI];
  int          m_idx  [NI];
  logic [3:0]  m_dout [NI];

  always #5 clk = ~clk;

  digit_scan_mux #(.DIGIT_W(4), .NUM_DIGITS(4), .SCAN_DIV(3), .LZ_BLANK(1)) dut_main (
    .clk(clk), .rst(rst), .in(in_w), .load(load), .en(en),
    .digit_out(dout_w[0]), .digit_sel(sel_w[0]), .blank(blank_w[0]), .frame_done(fd_w[0]));

  digit_scan_mux #(.DIGIT_W(4), .NUM_DIGITS(4), .SCAN_DIV(3), .LZ_BLANK(0)) dut_nlz (
    .clk(clk), .rst(rst), .in(in_w), .load(load), .en(en),
    .digit_out(dout_w[1]), .digit_sel(sel_w[1]), .blank(blank_w[1]), .frame_done(fd_w[1]));

  digit_scan_mux #(.DIGIT_W(4), .NUM_DIGITS(4), .SCAN_DIV(1), .LZ_BLANK(1)) dut_fast (
    .clk(clk), .rst(rst), .in(in_w), .load(load), .en(en),
    .digit_out(dout_w[2]), .digit_sel(sel_w[2]), .blank(blank_w[2]), .frame_done(fd_w[2]));

  function automatic int sdOf(input int i);
    return (i == 2) ? 1 : 3;
  endfunction

  function automatic bit lzbOf(input int i);
    return i != 1;
  endfunction

  function automatic logic [3:0] digitOf(input logic [15:0] w, input int idx);
    logic [15:0] s;
    s = w >> (4 * idx);
    return s[3:0];
  endfunction

  function automatic exp_t expFor(input int i);
    exp_t e;
    if (en) begin
      e.dout  = digitOf(m_disp[i], m_idx[i]);
      e.sel   = 4'(1 << m_idx[i]);
      e.blank = lzbOf(i) && (m_idx[i] != 0) && ((m_disp[i] >> (4 * m_idx[i])) == 16'h0);
      e.fd    = (m_div[i] == sdOf(i) - 1) && (m_idx[i] == 3);
    end else begin
      e.dout  = m_dout[i];
      e.sel   = 4'b0000;
      e.blank = 1'b1;
      e.fd    = 1'b0;
    end
    return e;
  endfunction

  function automatic row_t expRow();
    row_t r;
    for (int i = 0; i < NI; i++) r[i] = expFor(i);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    else
      passes++;
  endtask

  task automatic checkRow(input row_t r);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("u%0d.digit_out", i), 32'(dout_w[i]), 32'(r[i].dout));
      checkOutput($sformatf("u%0d.digit_sel", i), 32'(sel_w[i]), 32'(r[i].sel));
      checkOutput($sformatf("u%0d.blank", i), 32'(blank_w[i]), 32'(r[i].blank));
      checkOutput($sformatf("u%0d.frame_done", i), 32'(fd_w[i]), 32'(r[i].fd));
    end
  endtask

  task automatic checkReset(input string pre);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("%s.u%0d.digit_out", pre, i), 32'(dout_w[i]), 32'h0);
      checkOutput($sformatf("%s.u%0d.digit_sel", pre, i), 32'(sel_w[i]), 32'h0);
      checkOutput($sformatf("%s.u%0d.blank", pre, i), 32'(blank_w[i]), 32'h1);
      checkOutput($sformatf("%s.u%0d.frame_done", pre, i), 32'(fd_w[i]), 32'h0);
    end
  endtask

  // Reference model: expected outputs come from pre-edge state, then state advances.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
      for (int i = 0; i < NI; i++) begin
        m_disp[i] <= 16'h0;
        m_pend[i] <= 16'h0;
        m_pv[i]   <= 1'b0;
        m_div[i]  <= 0;
        m_idx[i]  <= 0;
        m_dout[i] <= 4'h0;
      end
    end else begin
      sb_q.push_back(expRow());
      for (int i = 0; i < NI; i++) begin
        if (load) begin
          m_pend[i] <= in_w;
          m_pv[i]   <= 1'b1;
        end else if (en && m_div[i] == sdOf(i) - 1 && m_idx[i] == 3 && m_pv[i]) begin
          m_pv[i] <= 1'b0;
        end
        if (en) begin
          m_dout[i] <= digitOf(m_disp[i], m_idx[i]);
          if (m_div[i] == sdOf(i) - 1) begin
            m_div[i] <= 0;
            m_idx[i] <= (m_idx[i] + 1) % 4;
            if (m_idx[i] == 3 && m_pv[i]) m_disp[i] <= m_pend[i];
          end else begin
            m_div[i] <= m_div[i] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst)                  checkReset("in_reset");
    else if (sb_q.size() == 0) checkOutput("sb_pending", 32'(sb_q.size()), 32'h1);
    else                      checkRow(sb_q.pop_front());
  end

  task automatic applyStimulus(input logic l, input logic [15:0] w, input logic e);
    load = l;
    in_w = w;
    en   = e;
    @(negedge clk);
    #1;
  endtask

  task automatic alignTo(input int idx, input int div);
    for (int k = 0; k < 16; k++) begin
      if (m_idx[0] == idx && m_div[0] == div) break;
      applyStimulus(1'b0, 16'h0, 1'b1);
    end
  endtask

  initial begin
    int fd_cnt [NI];
    int ones_seen, twos_seen;
    logic [15:0] rw;

    rst = 1'b1; load = 1'b0; en = 1'b0; in_w = 16'h0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    repeat (7) applyStimulus(1'b0, 16'h0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkReset("async");
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("release.digit_sel", 32'(sel_w[0]), 32'h1);
    checkOutput("release.digit_out", 32'(dout_w[0]), 32'h0);
    checkOutput("release.blank", 32'(blank_w[0]), 32'h0);

    applyStimulus(1'b1, 16'h12AB, 1'b1);
    repeat (14) applyStimulus(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < NI; i++) fd_cnt[i] = 0;
    repeat (24) begin
      applyStimulus(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < NI; i++) fd_cnt[i] += int'(fd_w[i]);
    end
    checkOutput("fd_per_24.main", 32'(fd_cnt[0]), 32'd2);
    checkOutput("fd_per_24.nlz", 32'(fd_cnt[1]), 32'd2);
    checkOutput("fd_per_24.fast", 32'(fd_cnt[2]), 32'd6);

    applyStimulus(1'b1, 16'h0050, 1'b1);
    repeat (26) applyStimulus(1'b0, 16'h0, 1'b1);
    applyStimulus(1'b1, 16'h0000, 1'b1);
    repeat (26) applyStimulus(1'b0, 16'h0, 1'b1);
    repeat (12) begin
      applyStimulus(1'b0, 16'h0, 1'b1);
      checkOutput("zero_word.blank", 32'(blank_w[0]), (sel_w[0] == 4'b0001) ? 32'h0 : 32'h1);
      checkOutput("zero_word.nlz_blank", 32'(blank_w[1]), 32'h0);
    end

    alignTo(1, 0);
    applyStimulus(1'b1, 16'h1111, 1'b1);
    applyStimulus(1'b1, 16'h2222, 1'b1);
    ones_seen = 0;
    twos_seen = 0;
    repeat (30) begin
      applyStimulus(1'b0, 16'h0, 1'b1);
      if (sel_w[0] != 4'b0000 && dout_w[0] == 4'h1) ones_seen++;
      if (sel_w[0] != 4'b0000 && dout_w[0] == 4'h2) twos_seen++;
    end
    checkOutput("never_1111", 32'(ones_seen), 32'h0);
    checkOutput("shows_2222", 32'(twos_seen > 0), 32'h1);

    alignTo(2, 1);
    for (int i = 0; i < NI; i++) fd_cnt[i] = 0;
    repeat (5) begin
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("paused.digit_sel", 32'(sel_w[0]), 32'h0);
      checkOutput("paused.blank", 32'(blank_w[0]), 32'h1);
      for (int i = 0; i < NI; i++) fd_cnt[i] += int'(fd_w[i]);
    end
    checkOutput("paused.frame_done", 32'(fd_cnt[0] + fd_cnt[1] + fd_cnt[2]), 32'h0);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("resume1.digit_sel", 32'(sel_w[0]), 32'h4);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("resume2.digit_sel", 32'(sel_w[0]), 32'h4);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("resume3.digit_sel", 32'(sel_w[0]), 32'h8);

    alignTo(0, 0);
    applyStimulus(1'b1, 16'h00A0, 1'b1);
    alignTo(3, 2);
    applyStimulus(1'b1, 16'h0B00, 1'b1);
    repeat (30) applyStimulus(1'b0, 16'h0, 1'b1);

    repeat (200) begin
      for (int d = 0; d < 4; d++)
        rw[d*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 7) == 0), rw, ($urandom_range(0, 9) != 0));
    end
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
- Time-multiplexed digit scanner for the multiplier result display.
- Generalises the fixed 2-nibble selector to NUM_DIGITS digits of DIGIT_W bits.
- Adds an internal scan prescaler, one-hot digit select, tear-free double-buffered word load, optional leading-zero blanking and a frame-done pulse.
- Sits between the multiplier product register and the seven-segment decoder / digit drivers.

Parameters:
- DIGIT_W, 4: bits per digit (>=1).
- NUM_DIGITS, 4: digit count (>=2); input word width = DIGIT_W*NUM_DIGITS.
- SCAN_DIV, 1000: clk cycles each digit is held (>=1; 1 = advance every cycle).
- LZ_BLANK, 1: 1 = blank leading zero digits; 0 = never blank on value.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in, input, DIGIT_W*NUM_DIGITS: word to display; digit k = in[k*DIGIT_W +: DIGIT_W], digit 0 least significant.
- load, input, 1: capture in into pending buffer this cycle.
- en, input, 1: scan enable; low = display off and counters frozen.
- digit_out, output, DIGIT_W: value of currently selected digit.
- digit_sel, output, NUM_DIGITS: one-hot select of active digit; all zero when off.
- blank, output, 1: 1 = suppress segments for this digit.
- frame_done, output, 1: one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- State:
  - div_cnt: 0..SCAN_DIV-1.
  - idx: 0..NUM_DIGITS-1.
  - disp_word: shown word.
  - pend_word, pend_valid: pending load.
- Reset (async, immediate): div_cnt=0, idx=0, disp_word=0, pend_word=0, pend_valid=0. Outputs: digit_out=0, digit_sel=0, blank=1, frame_done=0.
- Load: any cycle with load=1 (independent of en), pend_word<=in and pend_valid<=1. Back-to-back loads: last one wins.
- Scan, each cycle with en=1:
  - If div_cnt==SCAN_DIV-1: div_cnt<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
  - On that wrap: if pend_valid, disp_word<=pend_word and pend_valid<=0.
  - Otherwise: div_cnt<=div_cnt+1.
- Commit happens only at the frame wrap, so the display never tears mid-frame.
- Load coincident with commit: disp_word takes the old pend_word; pend_word takes the new in; pend_valid stays 1 (the new value commits at the next wrap).
- en=0: div_cnt, idx, disp_word frozen; load still accepted. On re-enable, scanning resumes at the same idx/div_cnt.
- Outputs are registered, computed every cycle from the current (pre-update) state, i.e. one cycle behind state:
  - en=1: digit_out<=disp_word digit idx; digit_sel<=1<<idx; blank<=lz(idx).
  - en=0: digit_sel<=0, blank<=1, digit_out holds.
- lz(idx) = LZ_BLANK && idx!=0 && disp_word digits idx..NUM_DIGITS-1 all zero. Digit 0 is never value-blanked, so 0 displays as "0".
- frame_done<=1 for exactly one cycle, the cycle after the wrap update (en=1, div_cnt==SCAN_DIV-1, idx==NUM_DIGITS-1). It is 0 otherwise and 0 while en=0.
- SCAN_DIV=1: idx advances every enabled cycle, and frame_done pulses every NUM_DIGITS cycles.
- Counter widths: $clog2 of range, minimum 1 bit. No arithmetic on the data word.

Decomposition:
- Shared package (mul_disp_pkg) holds:
  - defaults DIGIT_W_DEF=4, NUM_DIGITS_DEF=4, SCAN_DIV_DEF=1000;
  - function onehot(idx);
  - function lz_mask(word) returning the per-digit leading-zero vector.
- One natural sub-module: scan_prescaler (div_cnt, tick output, en gating). Everything else stays in digit_scan_mux.

Test Plan (DIGIT_W=4, NUM_DIGITS=4, SCAN_DIV=3, LZ_BLANK=1 unless noted):
1. Assert rst asynchronously mid-frame with idx=2 -> same-instant digit_sel=0, blank=1, digit_out=0, frame_done=0. After release with en=1 the first output is digit_sel=0001, digit_out=0, blank=0.
2. load in=16'h12AB once, en=1 -> after the first wrap, each frame shows digit_out B,A,2,1 with digit_sel 0001,0010,0100,1000, each held 3 cycles, blank=0. frame_done pulses once every 12 cycles.
3. Leading zeros: 16'h0050 -> digits 0,5,0,0 with blank 0,0,1,1. 16'h0000 -> blank 0,1,1,1. With LZ_BLANK=0 -> blank all 0.
4. Load 16'h1111 while digit 1 is displayed, then 16'h2222 one cycle later -> the rest of the current frame shows the old word. The next frame shows 2,2,2,2; 1111 is never displayed.
5. Drop en for 5 cycles at idx=2, div_cnt=1 -> next cycle digit_sel=0, blank=1, no frame_done. On re-enable, digit 2 is shown for its remaining 2 cycles, then digit 3.
6. load asserted exactly in the wrap cycle with pend=16'h00A0, in=16'h0B00 -> next frame shows 00A0, the following frame shows 0B00. SCAN_DIV=1 build: digit_sel rotates every cycle, frame_done every 4 cycles.
